// File: rtl/ballot_box_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ballot_box_arbiter_if
//  Description : Bundle between the four ballot-box front ends and the
//                arbiter/phase sequencer in front of the tally datapath.
//                master : requester side (drives req and fields, sees results)
//                slave  : arbiter side (samples requests, drives results)
//  Signals     : req[3:0], req_mode[7:0], req_userID[23:0], req_candidate[7:0]
//                grant[3:0], reject[3:0], out_valid, out_mode[1:0],
//                out_userID[5:0], out_candidate[1:0], phase[1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface ballot_box_arbiter_if;
    logic [3:0]  req;
    logic [7:0]  req_mode;
    logic [23:0] req_userID;
    logic [7:0]  req_candidate;
    logic [3:0]  grant;
    logic [3:0]  reject;
    logic        out_valid;
    logic [1:0]  out_mode;
    logic [5:0]  out_userID;
    logic [1:0]  out_candidate;
    logic [1:0]  phase;

    modport master (
        output req, req_mode, req_userID, req_candidate,
        input  grant, reject, out_valid, out_mode, out_userID, out_candidate, phase
    );

    modport slave (
        input  req, req_mode, req_userID, req_candidate,
        output grant, reject, out_valid, out_mode, out_userID, out_candidate, phase
    );
endinterface
`default_nettype wire

// File: rtl/ballot_box_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ballot_box_arbiter
//  Description : Round-robin arbiter for four ballot boxes sharing one tally
//                port, with userID ownership check and election phase
//                sequencer (registration -> voting -> result).
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - ballot_box_arbiter_if.slave (requests in, grant /
//                       reject / forwarded command / phase out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ballot_box_arbiter #(
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100,
    parameter int CNT_W       = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ballot_box_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_REG_END = CNT_W'(REG_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REG_CYCLES + VOTE_CYCLES);

    typedef enum logic [1:0] {
        PH_REG    = 2'b00,
        PH_VOTE   = 2'b01,
        PH_RESULT = 2'b10
    } phase_t;

    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        grant_q, grant_d;
    logic [3:0]        reject_q, reject_d;
    logic              valid_q, valid_d;
    logic [1:0]        mode_q, mode_d;
    logic [5:0]        uid_q, uid_d;
    logic [1:0]        cand_q, cand_d;

    logic [3:0]        w_elig;
    logic              w_found;
    logic [1:0]        w_win;

    // Per-box views of the packed request fields
    logic [1:0]        w_mode_a [4];
    logic [5:0]        w_uid_a  [4];
    logic [1:0]        w_cand_a [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign w_mode_a[g] = bus.req_mode[2*g +: 2];
        assign w_uid_a[g]  = bus.req_userID[6*g +: 6];
        assign w_cand_a[g] = bus.req_candidate[2*g +: 2];
    end

    // Box granted this cycle still shows its old request; masking it
    // prevents the same transaction from being taken twice.
    assign w_elig = bus.req & ~grant_q;

    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_win   = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Phase follows the counter value being loaded, so phase changes on
        // the same edge the counter reaches the boundary.
        if (cnt_d < C_REG_END)      phase_d = PH_REG;
        else if (cnt_d < C_CNT_MAX) phase_d = PH_VOTE;
        else                        phase_d = PH_RESULT;

        ptr_d    = ptr_q;
        grant_d  = '0;
        reject_d = '0;
        valid_d  = 1'b0;
        mode_d   = mode_q;
        uid_d    = uid_q;
        cand_d   = cand_q;

        if (w_found) begin
            grant_d[w_win] = 1'b1;
            ptr_d          = w_win + 2'd1;
            // Judged against the phase currently published, not the next one
            if ((w_uid_a[w_win][5:4] != w_win) || (phase_q == PH_RESULT)) begin
                reject_d[w_win] = 1'b1;
            end else begin
                valid_d = 1'b1;
                mode_d  = w_mode_a[w_win];
                uid_d   = w_uid_a[w_win];
                cand_d  = w_cand_a[w_win];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= PH_REG;
            ptr_q    <= '0;
            grant_q  <= '0;
            reject_q <= '0;
            valid_q  <= 1'b0;
            mode_q   <= '0;
            uid_q    <= '0;
            cand_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            reject_q <= reject_d;
            valid_q  <= valid_d;
            mode_q   <= mode_d;
            uid_q    <= uid_d;
            cand_q   <= cand_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.reject        = reject_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_mode      = mode_q;
    assign bus.out_userID    = uid_q;
    assign bus.out_candidate = cand_q;
    assign bus.phase         = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_ballot_box_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ballot_box_arbiter
//  Description : Self-checking bench for ballot_box_arbiter. A behavioural
//                model (integer cycle count, modulo pointer scan) predicts
//                every output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_box_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ballot_box_arbiter_if bus ();

    ballot_box_arbiter #(
        .REG_CYCLES (100),
        .VOTE_CYCLES(100),
        .CNT_W      (9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_cnt;
    int         m_ptr;
    int         m_phase;
    logic [3:0] m_grant;
    logic [3:0] m_reject;
    logic       m_valid;
    logic [1:0] m_mode;
    logic [5:0] m_uid;
    logic [1:0] m_cand;

    function automatic int phase_of(input int c);
        if (c < 100) return 0;
        if (c < 200) return 1;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_box(input int i, input logic r, input logic [1:0] mode,
                           input logic [5:0] uid, input logic [1:0] cand);
        bus.req[i]                 = r;
        bus.req_mode[2*i +: 2]     = mode;
        bus.req_userID[6*i +: 6]   = uid;
        bus.req_candidate[2*i +: 2] = cand;
    endtask

    // Predict, clock, then compare everything one time unit after the edge
    task automatic step();
        logic [3:0] elig;
        logic [5:0] uid;
        int         win;
        if (rst) begin
            m_cnt = 0; m_ptr = 0; m_phase = 0;
            m_grant = '0; m_reject = '0; m_valid = 1'b0;
            m_mode = '0; m_uid = '0; m_cand = '0;
        end else begin
            elig = bus.req & ~m_grant;
            win  = -1;
            for (int k = 0; k < 4; k++)
                if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            m_grant = '0; m_reject = '0; m_valid = 1'b0;
            if (win >= 0) begin
                m_grant[win] = 1'b1;
                m_ptr = (win + 1) % 4;
                uid = bus.req_userID[6*win +: 6];
                if ((int'(uid) / 16) != win || m_phase == 2) begin
                    m_reject[win] = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_uid   = uid;
                    m_mode  = bus.req_mode[2*win +: 2];
                    m_cand  = bus.req_candidate[2*win +: 2];
                end
            end
            m_cnt   = (m_cnt < 200) ? m_cnt + 1 : 200;
            m_phase = phase_of(m_cnt);
        end
        @(posedge clk);
        #1;
        check("grant",         32'(bus.grant),         32'(m_grant));
        check("reject",        32'(bus.reject),        32'(m_reject));
        check("out_valid",     32'(bus.out_valid),     32'(m_valid));
        check("out_mode",      32'(bus.out_mode),      32'(m_mode));
        check("out_userID",    32'(bus.out_userID),    32'(m_uid));
        check("out_candidate", 32'(bus.out_candidate), 32'(m_cand));
        check("phase",         32'(bus.phase),         32'(m_phase));
    endtask

    // Requester behaviour: hold until granted, then present something new
    task automatic random_requests();
        logic [1:0] hi;
        for (int i = 0; i < 4; i++) begin
            if (!bus.req[i] || m_grant[i]) begin
                hi = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(i);
                set_box(i, 1'($urandom_range(0, 99) < 60), 2'($urandom_range(0, 1)),
                        {hi, 4'($urandom_range(0, 15))}, 2'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        int valid_seen;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;

        rst               = 1'b1;
        bus.req           = '0;
        bus.req_mode      = '0;
        bus.req_userID    = '0;
        bus.req_candidate = '0;
        step();
        step();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        rst = 1'b0;

        // Single request from box 0
        set_box(0, 1'b1, 2'd0, 6'd5, 2'd1);
        step();
        check("dir_grant0", 32'(bus.grant),      32'h1);
        check("dir_valid0", 32'(bus.out_valid),  32'h1);
        check("dir_uid0",   32'(bus.out_userID), 32'd5);
        bus.req = '0;
        step();

        // All four holding from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        set_box(0, 1'b1, 2'd0, 6'd3,  2'd0);
        set_box(1, 1'b1, 2'd0, 6'd20, 2'd1);
        set_box(2, 1'b1, 2'd1, 6'd40, 2'd2);
        set_box(3, 1'b1, 2'd1, 6'd60, 2'd3);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_order", 32'(bus.grant), 32'(exp_seq[k]));
        end
        bus.req = '0;
        step();

        // Ownership violation from box 1
        set_box(1, 1'b1, 2'd1, 6'd3, 2'd2);
        step();
        check("own_grant",  32'(bus.grant),     32'h2);
        check("own_reject", 32'(bus.reject),    32'h2);
        check("own_valid",  32'(bus.out_valid), 32'h0);
        bus.req = '0;
        step();

        // Box 2 still showing its request while the grant is visible
        valid_seen = 0;
        set_box(2, 1'b1, 2'd1, 6'd40, 2'd0);
        step(); if (bus.out_valid) valid_seen++;
        step(); if (bus.out_valid) valid_seen++;
        bus.req = '0;
        step(); if (bus.out_valid) valid_seen++;
        step(); if (bus.out_valid) valid_seen++;
        check("no_dup_valid", 32'(valid_seen), 32'd1);

        // Timeline run with random traffic, reset at cycle 150
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            random_requests();
            step();
            if (m_cnt == 100) check("phase_vote_start", 32'(bus.phase), 32'd1);
            if (m_cnt == 99)  check("phase_reg_end",    32'(bus.phase), 32'd0);
        end
        for (int i = 0; i < 4; i++) set_box(i, 1'b1, 2'd1, {2'(i), 4'd1}, 2'd0);
        rst = 1'b1;
        step();
        check("mid_rst_grant", 32'(bus.grant),     32'h0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_phase", 32'(bus.phase),     32'h0);
        rst = 1'b0;
        step();
        check("mid_rst_ptr", 32'(bus.grant), 32'h1);
        for (int c = 0; c < 205; c++) begin
            random_requests();
            step();
            if (m_cnt == 200) check("phase_result", 32'(bus.phase), 32'd2);
        end

        // Request while in result phase
        bus.req = '0;
        step();
        set_box(0, 1'b1, 2'd1, 6'd5, 2'd1);
        step();
        check("res_grant",  32'(bus.grant),     32'h1);
        check("res_reject", 32'(bus.reject),    32'h1);
        check("res_valid",  32'(bus.out_valid), 32'h0);
        bus.req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ballot_box_arbiter.md
# ballot_box_arbiter

Round-robin arbiter and phase sequencer placed in front of the avatar-election tally datapath. Four ballot-box front ends (box 0..3, box i serving userIDs with userID[5:4] == i) compete for the single tally port. The block grants one requester per cycle, checks box ownership of the userID, and forwards accepted transactions as a registered one-cycle command. It also owns the election timeline (registration, voting, result) and publishes the current phase.

## Interface
- REG_CYCLES, 100, length of the registration phase in clock cycles
- VOTE_CYCLES, 100, length of the voting phase in clock cycles
- CNT_W, 9, cycle-counter width; must hold REG_CYCLES+VOTE_CYCLES
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req  in  4  req[i]=1: box i presents a transaction
- req_mode  in  8  bits [2i+1:2i] = mode of box i (0 register, 1 vote)
- req_userID  in  24  bits [6i+5:6i] = userID of box i
- req_candidate  in  8  bits [2i+1:2i] = candidate of box i
- grant  out  4  one-hot, one-cycle pulse: box i's transaction taken
- reject  out  4  one-cycle pulse coincident with grant: transaction dropped
- out_valid  out  1  one-cycle command strobe to tally datapath
- out_mode  out  2  forwarded mode
- out_userID  out  6  forwarded userID
- out_candidate  out  2  forwarded candidate
- phase  out  2  00 registration, 01 voting, 10 result

## Operation
- Reset: grant=0, reject=0, out_valid=0, out_mode/out_userID/out_candidate=0, phase=00, cycle counter=0, priority pointer=0.
- Cycle counter: +1 each non-reset cycle, saturates at REG_CYCLES+VOTE_CYCLES.
- Phase decoded from counter: cnt < REG_CYCLES -> 00; cnt < REG_CYCLES+VOTE_CYCLES -> 01; else 10. Phase is registered.
- Eligible set: req[i] & ~grant[i] (the box granted in the current cycle is masked, so a stale held req is never serviced twice).
- Winner: first eligible box scanning from pointer upward, wrapping 3 -> 0. None eligible: no grant, pointer unchanged.
- After any grant to box i (accepted or rejected): pointer <= (i+1) mod 4.
- Reject conditions (checked on winner): userID[5:4] != i, or phase == 10. Rejected: grant[i]=1, reject[i]=1, out_valid=0, out_* hold previous value.
- Accepted: grant[i]=1, reject=0, out_valid=1, out_* <= box i fields. Mode is forwarded unchecked; wrong-phase mode errors are flagged by the tally datapath.
- Requester handshake: hold req and fields stable until grant[i] seen; in the grant cycle either drop req or present the next transaction.

## Timing
- Arbitration samples req/fields at edge t; grant, reject, out_* valid after edge t+1 for exactly one cycle. Latency 1 cycle.
- Throughput: one grant per cycle overall; same box at most every other cycle.
- Starvation bound: a continuously requesting box is granted within 4 cycles.
- Phase transition: first cycle with phase=01 follows the REG_CYCLES-th non-reset edge; transactions sampled in that same cycle are judged against the registered phase, not the next one.
- RST mid-operation: all outputs return to reset values on the next edge; any in-flight grant is lost, requesters re-present.
- req with all four eligible and pointer=2: order 2,3,0,1.

## Test plan
- Reset then req=0001, box 0 userID=5, mode=0 -> grant=0001, out_valid=1, out_userID=5 one cycle later; pointer to 1.
- All four req held, matching userIDs (3,20,40,60) -> grants 0001,0010,0100,1000 on consecutive cycles, each out_valid=1, out_userID matches.
- Box 1 requests userID=3 -> grant=0010, reject=0010, out_valid=0, out_userID unchanged.
- Box 2 holds req two cycles after grant without changing fields -> single grant, no duplicate out_valid.
- Run 200 idle cycles: phase 00 through cycle 99, 01 at cycles 100..199, 10 from 200; req in phase 10 -> grant with reject, out_valid=0.
- Assert RST at cycle 150 with requests pending -> next cycle grant=0, out_valid=0, phase=00, pointer restarts at box 0.
